// File: rtl/memory_2rw_wb_param_if.sv
// memory_2rw_wb_param_if: one pipelined Wishbone B4 port, named from the slave's point of view.
interface memory_2rw_wb_param_if #(parameter int DATA_WIDTH = 32);
    logic                    wb_cyc_i;
    logic                    wb_stb_i;
    logic                    wb_we_i;
    logic [31:0]             wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH/8-1:0] wb_sel_i;
    logic                    wb_stall_o;
    logic                    wb_ack_o;
    logic                    wb_err_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
    );
endinterface

// File: rtl/memory_2rw_wb_param.sv
// memory_2rw_wb_param: dual-port pipelined Wishbone RAM, port 0 data bus, port 1 instruction bus.
module memory_2rw_wb_param #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    DEPTH        = 120000,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "",
    parameter bit    ERR_EN       = 1'b1
) (
    input logic                  wb_clk_i,
    input logic                  wb_rst_ni,
    memory_2rw_wb_param_if.slave port0,
    memory_2rw_wb_param_if.slave port1
);
    localparam int NB       = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int AW       = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            cyc, req, we, oor, ack_o, err_o;
    logic [31:0]           word [2];
    logic [AW-1:0]         idx [2];
    logic [NB-1:0]         sel [2];
    logic [DATA_WIDTH-1:0] wdat [2], dat_o [2];

    assign cyc     = {port1.wb_cyc_i, port0.wb_cyc_i};
    assign req     = cyc & {port1.wb_stb_i, port0.wb_stb_i} & {2{wb_rst_ni}};
    assign we      = {port1.wb_we_i, port0.wb_we_i};
    assign word[0] = port0.wb_adr_i >> ADDR_LSB;
    assign word[1] = port1.wb_adr_i >> ADDR_LSB;
    assign sel[0]  = port0.wb_sel_i;
    assign sel[1]  = port1.wb_sel_i;
    assign wdat[0] = port0.wb_dat_i;
    assign wdat[1] = port1.wb_dat_i;

    always_ff @(posedge wb_clk_i) begin
        for (int p = 1; p >= 0; p--)
            for (int b = 0; b < NB; b++)
                if (req[p] && we[p] && !oor[p] && sel[p][b])
                    mem[idx[p]][8*b +: 8] <= wdat[p][8*b +: 8];
    end

    for (genvar g = 0; g < 2; g++) begin : g_port
        logic                  sv, sw, so, ack_d, err_d, ack_q, err_q;
        logic [DATA_WIDTH-1:0] sd, dat_d, dat_q;
        assign idx[g] = word[g][AW-1:0];
        assign oor[g] = word[g] >= 32'(DEPTH);
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  v_q, w_q, o_q;
            logic [DATA_WIDTH-1:0] d_q;
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    {v_q, w_q, o_q, d_q} <= '0;
                end else begin
                    {v_q, w_q, o_q, d_q} <= {req[g], we[g], oor[g], mem[idx[g]]};
                end
            end
            assign {sv, sw, so, sd} = {v_q, w_q, o_q, d_q};
        end else begin : g_lat1
            assign {sv, sw, so, sd} = {req[g], we[g], oor[g], mem[idx[g]]};
        end
        assign ack_d = cyc[g] & sv & (~so | ~ERR_EN);
        assign err_d = cyc[g] & sv & so & ERR_EN;
        assign dat_d = (cyc[g] & sv & (so | ~sw)) ? (so ? '0 : sd) : dat_q;
        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                ack_q <= 1'b0;
                err_q <= 1'b0;
                dat_q <= '0;
            end else begin
                ack_q <= ack_d;
                err_q <= err_d;
                dat_q <= dat_d;
            end
        end
        assign ack_o[g] = ack_q;
        assign err_o[g] = err_q;
        assign dat_o[g] = dat_q;
    end

    assign port0.wb_stall_o = 1'b0;
    assign port1.wb_stall_o = 1'b0;
    assign port0.wb_ack_o   = ack_o[0];
    assign port1.wb_ack_o   = ack_o[1];
    assign port0.wb_err_o   = err_o[0];
    assign port1.wb_err_o   = err_o[1];
    assign port0.wb_dat_o   = dat_o[0];
    assign port1.wb_dat_o   = dat_o[1];
endmodule

// File: tb/tb_memory_2rw_wb_param.sv
// tb_memory_2rw_wb_param: drives one stimulus stream into a LAT=1/ERR_EN=1 and a LAT=2/ERR_EN=0
// instance (both DEPTH=1024) and scoreboards every completion, including its arrival cycle.
module tb_memory_2rw_wb_param;
    typedef struct packed {
        logic        v;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } req_t;
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] dat;
        logic [31:0] at;
    } ent_t;
    localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_OOR = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cnt = '0;
    logic        cyc_r [2], stb_r [2], we_r [2];
    logic [31:0] adr_r [2], dat_r [2];
    logic [3:0]  sel_r [2];
    logic [3:0]  ack_w, err_w, stall_w;
    logic [31:0] dat_w [4];
    logic [31:0] last [4];
    ent_t        sbq [4][$];
    int          passed = 0, failed = 0, total = 0;

    memory_2rw_wb_param_if ia0 ();
    memory_2rw_wb_param_if ia1 ();
    memory_2rw_wb_param_if ib0 ();
    memory_2rw_wb_param_if ib1 ();

    memory_2rw_wb_param #(.DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(1), .ERR_EN(1'b1)) ua (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .port0(ia0), .port1(ia1));
    memory_2rw_wb_param #(.DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(2), .ERR_EN(1'b0)) ub (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .port0(ib0), .port1(ib1));

    assign {ia0.wb_cyc_i, ib0.wb_cyc_i, ia1.wb_cyc_i, ib1.wb_cyc_i} = {{2{cyc_r[0]}}, {2{cyc_r[1]}}};
    assign {ia0.wb_stb_i, ib0.wb_stb_i, ia1.wb_stb_i, ib1.wb_stb_i} = {{2{stb_r[0]}}, {2{stb_r[1]}}};
    assign {ia0.wb_we_i, ib0.wb_we_i, ia1.wb_we_i, ib1.wb_we_i}     = {{2{we_r[0]}}, {2{we_r[1]}}};
    assign {ia0.wb_adr_i, ib0.wb_adr_i, ia1.wb_adr_i, ib1.wb_adr_i} = {{2{adr_r[0]}}, {2{adr_r[1]}}};
    assign {ia0.wb_dat_i, ib0.wb_dat_i, ia1.wb_dat_i, ib1.wb_dat_i} = {{2{dat_r[0]}}, {2{dat_r[1]}}};
    assign {ia0.wb_sel_i, ib0.wb_sel_i, ia1.wb_sel_i, ib1.wb_sel_i} = {{2{sel_r[0]}}, {2{sel_r[1]}}};
    assign ack_w   = {ib1.wb_ack_o, ib0.wb_ack_o, ia1.wb_ack_o, ia0.wb_ack_o};
    assign err_w   = {ib1.wb_err_o, ib0.wb_err_o, ia1.wb_err_o, ia0.wb_err_o};
    assign stall_w = {ib1.wb_stall_o, ib0.wb_stall_o, ia1.wb_stall_o, ia0.wb_stall_o};
    assign dat_w[0] = ia0.wb_dat_o;
    assign dat_w[1] = ia1.wb_dat_o;
    assign dat_w[2] = ib0.wb_dat_o;
    assign dat_w[3] = ib1.wb_dat_o;

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 32'd1;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t rd(input logic [31:0] a, input logic [31:0] x);
        return '{1'b1, 1'b0, a, 32'h0, 4'h0, x};
    endfunction
    function automatic req_t wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        return '{1'b1, 1'b1, a, d, s, 32'h0};
    endfunction
    function automatic req_t nop();
        return '0;
    endfunction

    // Index i = dut*2 + port; dut 0 has latency 1, dut 1 latency 2.
    task automatic step(input req_t r0, input req_t r1);
        req_t r [2];
        ent_t e;
        r[0] = r0;
        r[1] = r1;
        for (int p = 0; p < 2; p++) begin
            stb_r[p] = r[p].v;
            we_r[p]  = r[p].we;
            adr_r[p] = r[p].adr;
            dat_r[p] = r[p].dat;
            sel_r[p] = r[p].sel;
            if (r[p].v && cyc_r[p] && rst_n)
                for (int d = 0; d < 2; d++) begin
                    e.kind = (r[p].adr >> 2) >= 32'd1024 ? K_OOR : r[p].we ? K_WR : K_RD;
                    e.dat  = r[p].exp;
                    e.at   = cnt + 32'(1 + d);
                    sbq[d*2+p].push_back(e);
                end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(nop(), nop());
    endtask

    always @(negedge clk) begin
        ent_t        e;
        logic        xe;
        logic [31:0] xd;
        for (int i = 0; i < 4; i++)
            if (ack_w[i] || err_w[i]) begin
                if (sbq[i].size() == 0) begin
                    chk($sformatf("spurious_cpl_dut%0d", i), {ack_w[i], err_w[i]}, 2'b00);
                end else begin
                    e  = sbq[i].pop_front();
                    xe = e.kind == K_OOR && i < 2;
                    xd = e.kind == K_RD ? e.dat : e.kind == K_WR ? last[i] : 32'h0;
                    last[i] = xd;
                    chk($sformatf("cpl_dut%0d {cycle,ack,err,dat}", i),
                        {cnt, ack_w[i], err_w[i], dat_w[i]}, {e.at, ~xe, xe, xd});
                end
            end
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            cyc_r[p] = 1'b0; stb_r[p] = 1'b0; we_r[p] = 1'b0;
            adr_r[p] = '0;   dat_r[p] = '0;   sel_r[p] = '0;
        end
        for (int i = 0; i < 4; i++) last[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("reset_dut%0d {ack,err,dat}", i), {ack_w[i], err_w[i], dat_w[i]}, '0);
        chk("stall", stall_w, '0);
        rst_n = 1'b1;
        cyc_r[0] = 1'b1;
        cyc_r[1] = 1'b1;
        // basic write/read on both ports, low address bits ignored
        step(wr(32'h100, 32'hDEADBEEF, 4'hF), nop());
        step(rd(32'h100, 32'hDEADBEEF), nop());
        step(nop(), rd(32'h100, 32'hDEADBEEF));
        step(rd(32'h103, 32'hDEADBEEF), nop());
        // byte merge, and a sel=0 write that changes nothing
        step(wr(32'h20, 32'h11223344, 4'hF), nop());
        step(wr(32'h20, 32'hAABBCCDD, 4'b0101), nop());
        step(wr(32'h20, 32'hFFFFFFFF, 4'b0000), nop());
        step(rd(32'h20, 32'h11BB33DD), nop());
        // collisions at 0x40
        step(wr(32'h40, 32'h000000FF, 4'b0011), wr(32'h40, 32'hAAAAAAAA, 4'b1111));
        step(rd(32'h40, 32'hAAAA00FF), rd(32'h40, 32'hAAAA00FF));
        step(rd(32'h40, 32'hAAAA00FF), wr(32'h40, 32'h00000055, 4'hF));
        step(wr(32'h40, 32'h00000066, 4'hF), rd(32'h40, 32'h00000055));
        step(rd(32'h40, 32'h00000066), nop());
        // out-of-range and the last in-range word
        step(wr(32'h0, 32'hCAFEF00D, 4'hF), wr(32'hFFC, 32'h5A5AA5A5, 4'hF));
        step(rd(32'h1000, 32'h0), rd(32'hFFC, 32'h5A5AA5A5));
        step(wr(32'h1000, 32'hFFFFFFFF, 4'hF), rd(32'h80000000, 32'h0));
        step(rd(32'h0, 32'hCAFEF00D), rd(32'hFFFFFFFC, 32'h0));
        idle(2);
        // preload 1..4, then a back-to-back read burst
        step(wr(32'h0, 32'd1, 4'hF), nop());
        step(wr(32'h4, 32'd2, 4'hF), nop());
        step(wr(32'h8, 32'd3, 4'hF), nop());
        step(wr(32'hC, 32'd4, 4'hF), nop());
        step(rd(32'h0, 32'd1), nop());
        step(rd(32'h4, 32'd2), nop());
        step(rd(32'h8, 32'd3), nop());
        step(rd(32'hC, 32'd4), nop());
        idle(3);
        // abort: cyc drops one cycle after the read, so only the latency-1 completion survives
        step(rd(32'h100, 32'hDEADBEEF), nop());
        cyc_r[0] = 1'b0;
        stb_r[0] = 1'b0;
        for (int d = 0; d < 2; d++)
            while (sbq[d*2].size() > 0 && sbq[d*2][sbq[d*2].size()-1].at > cnt)
                void'(sbq[d*2].pop_back());
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("abort_lat2 {ack,err}", {ack_w[2], err_w[2]}, 2'b00);
        end
        cyc_r[0] = 1'b1;
        // reset mid-burst: outputs clear at once, writes during reset are ignored
        step(rd(32'h20, 32'h11BB33DD), rd(32'h40, 32'h00000066));
        step(rd(32'h100, 32'hDEADBEEF), rd(32'h0, 32'd1));
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sbq[i].delete();
            last[i] = '0;
        end
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("async_reset_dut%0d {ack,err,dat}", i), {ack_w[i], err_w[i], dat_w[i]}, '0);
        step(wr(32'h100, 32'h0BADBAD0, 4'hF), wr(32'h20, 32'h0BADBAD0, 4'hF));
        step(wr(32'h100, 32'h0BADBAD0, 4'hF), wr(32'h20, 32'h0BADBAD0, 4'hF));
        rst_n = 1'b1;
        idle(1);
        step(rd(32'h100, 32'hDEADBEEF), rd(32'h20, 32'h11BB33DD));
        step(rd(32'hC, 32'd4), rd(32'h40, 32'h00000066));
        idle(4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("drain_dut%0d pending", i), sbq[i].size(), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
